// File: rtl/bsg_channel_narrow_rr_if.sv
// Handshake bundle between wide requesters, the narrowing round-robin
// scheduler and the narrow consumer. The scheduler uses the slave view; the
// environment driving requests and accepting beats uses the master view.
interface bsg_channel_narrow_rr_if #(
   parameter int els_p       = 4,
   parameter int width_in_p  = 16,
   parameter int width_out_p = 8
);
   localparam int id_width_lp = (els_p > 1) ? $clog2(els_p) : 1;

   logic [els_p-1:0]            v_i;
   logic [els_p*width_in_p-1:0] data_i;
   logic [els_p-1:0]            yumi_o;
   logic                        v_o;
   logic [width_out_p-1:0]      data_o;
   logic [id_width_lp-1:0]      src_id_o;
   logic                        last_o;
   logic                        ready_i;

   modport slave (
      input  v_i, data_i, ready_i,
      output yumi_o, v_o, data_o, src_id_o, last_o
   );

   modport master (
      output v_i, data_i, ready_i,
      input  yumi_o, v_o, data_o, src_id_o, last_o
   );
endinterface

// File: rtl/bsg_channel_narrow_rr.sv
// Round-robin scheduler: grants one wide requester at a time and streams its
// word out as narrow beats, low slice first, dequeuing it on the last beat.
module bsg_channel_narrow_rr #(
   parameter int els_p       = 4,
   parameter int width_in_p  = 16,
   parameter int width_out_p = 8
) (
   input logic                    clk_i,
   input logic                    reset_n_i,
   bsg_channel_narrow_rr_if.slave ch
);
   localparam int beats_lp       = width_in_p / width_out_p;
   localparam int id_width_lp    = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int beat_width_lp  = $clog2(beats_lp);

   typedef logic [id_width_lp-1:0]   id_t;
   typedef logic [beat_width_lp-1:0] beat_t;
   typedef enum logic {IDLE, SEND}   state_e;

   localparam id_t                  last_id_lp   = id_t'(els_p - 1);
   localparam beat_t                last_beat_lp = beat_t'(beats_lp - 1);
   localparam logic [id_width_lp:0] els_wide_lp  = (id_width_lp + 1)'(els_p);

   state_e state_r;
   id_t    grant_r, ptr_r, src_r;
   beat_t  beat_r;
   logic   v_r, last_r;

   logic [els_p-1:0] grant_onehot, arb_req;
   id_t              arb_ptr, next_ptr, winner, arb_idx;
   logic [id_width_lp:0] arb_sum;
   logic             found, last_hs;

   assign grant_onehot = {{(els_p-1){1'b0}}, 1'b1} << grant_r;
   assign next_ptr     = (grant_r == last_id_lp) ? '0 : grant_r + id_t'(1);
   assign last_hs      = (state_r == SEND) && ch.ready_i && (beat_r == last_beat_lp);

   // Rotating-priority pick: idle uses the stored pointer, the last beat
   // re-arbitrates with the finishing requester masked and the advanced pointer.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      arb_req = ch.v_i;
      arb_ptr = ptr_r;
      found   = 1'b0;
      winner  = '0;
      arb_sum = '0;
      arb_idx = '0;
      if (state_r == SEND) begin
         arb_req = ch.v_i & ~grant_onehot;
         arb_ptr = next_ptr;
      end
      for (int i = 0; i < els_p; i++) begin
         arb_sum = {1'b0, arb_ptr} + (id_width_lp + 1)'(i);
         if (arb_sum >= els_wide_lp) arb_sum = arb_sum - els_wide_lp;
         arb_idx = id_t'(arb_sum);
         if (!found && arb_req[arb_idx]) begin
            found  = 1'b1;
            winner = arb_idx;
         end
      end
   end

   // Scheduler FSM with registered beat-side outputs.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      // NOTE: only control state is reset; the beat data is muxed live from
      // data_i and gated by v_r, so no wide storage needs clearing.
      if (!reset_n_i) begin
         state_r <= IDLE;
         grant_r <= '0;
         beat_r  <= '0;
         ptr_r   <= '0;
         v_r     <= 1'b0;
         last_r  <= 1'b0;
         src_r   <= '0;
      end else begin
         // NOTE: non-blocking so every flop sees pre-edge values of its peers.
         case (state_r)
            IDLE: begin
               if (found) begin
                  state_r <= SEND;
                  grant_r <= winner;
                  src_r   <= winner;
                  beat_r  <= '0;
                  v_r     <= 1'b1;
                  last_r  <= 1'b0;
               end
            end
            SEND: begin
               if (ch.ready_i) begin
                  if (beat_r != last_beat_lp) begin
                     beat_r <= beat_r + beat_t'(1);
                     last_r <= (beat_r + beat_t'(1)) == last_beat_lp;
                  end else begin
                     ptr_r  <= next_ptr;
                     beat_r <= '0;
                     last_r <= 1'b0;
                     if (found) begin
                        grant_r <= winner;
                        src_r   <= winner;
                     end else begin
                        state_r <= IDLE;
                        v_r     <= 1'b0;
                        src_r   <= '0;
                     end
                  end
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Narrow beat slice of the granted word; zero while nothing is granted.
   always_comb begin
      ch.data_o = '0;
      if (v_r) begin
         ch.data_o = ch.data_i[int'(grant_r)*width_in_p + int'(beat_r)*width_out_p +: width_out_p];
      end
   end

   assign ch.v_o      = v_r;
   assign ch.src_id_o = src_r;
   assign ch.last_o   = last_r;
   assign ch.yumi_o   = last_hs ? grant_onehot : '0;
endmodule

// File: tb/tb_bsg_channel_narrow_rr.sv
// Self-checking bench for bsg_channel_narrow_rr: directed scenarios plus random
// traffic, all compared against a beat-queue reference model.
module tb_bsg_channel_narrow_rr;
   localparam int ELS   = 4;
   localparam int WI    = 16;
   localparam int WO    = 8;
   localparam int BEATS = WI / WO;

   logic clk_i = 1'b0;
   logic reset_n_i;
   always #5 clk_i = ~clk_i;

   bsg_channel_narrow_rr_if #(.els_p(ELS), .width_in_p(WI), .width_out_p(WO)) ch();

   bsg_channel_narrow_rr #(.els_p(ELS), .width_in_p(WI), .width_out_p(WO)) dut (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .ch        (ch)
   );

   logic [ELS-1:0] req_v;
   logic [WI-1:0]  words [ELS];
   logic           ready;

   assign ch.v_i     = req_v;
   assign ch.ready_i = ready;
   for (genvar k = 0; k < ELS; k++) begin : g_data
      assign ch.data_i[k*WI +: WI] = words[k];
   end

   int n_vec = 0;
   int n_err = 0;

   // Reference model: pending beats of the granted word as a queue.
   bit             m_busy;
   int             m_src;
   int             m_ptr;
   logic [WO-1:0]  m_q [$];

   logic           obs_v, obs_last;
   logic [WO-1:0]  obs_data;
   logic [1:0]     obs_src;
   logic [ELS-1:0] obs_yumi;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int pick(input logic [ELS-1:0] req, input int start);
      for (int i = 0; i < ELS; i++) begin
         int k = (start + i) % ELS;
         if (req[k]) return k;
      end
      return -1;
   endfunction

   task automatic grant_word(input int k);
      m_busy = 1'b1;
      m_src  = k;
      m_q.delete();
      for (int b = 0; b < BEATS; b++) m_q.push_back(words[k][b*WO +: WO]);
   endtask

   task automatic raise(input int k, input logic [WI-1:0] w);
      words[k] = w;
      req_v[k] = 1'b1;
   endtask

   // One clock: sample at the falling edge, compare, advance the model,
   // then release requesters whose word was dequeued.
   task automatic cycle();
      logic [WO-1:0]  e_data;
      bit             e_last;
      logic [ELS-1:0] e_yumi;
      int             w;
      @(negedge clk_i);
      obs_v    = ch.v_o;
      obs_data = ch.data_o;
      obs_src  = ch.src_id_o;
      obs_last = ch.last_o;
      obs_yumi = ch.yumi_o;
      e_data = m_busy ? m_q[0] : '0;
      e_last = m_busy && (m_q.size() == 1);
      e_yumi = (m_busy && ready && e_last) ? (ELS'(1) << m_src) : '0;
      check("v_o",      32'(obs_v),    32'(m_busy));
      check("data_o",   32'(obs_data), 32'(e_data));
      check("src_id_o", 32'(obs_src),  m_busy ? 32'(m_src) : 32'd0);
      check("last_o",   32'(obs_last), 32'(e_last));
      check("yumi_o",   32'(obs_yumi), 32'(e_yumi));
      if (obs_v === 1'b1) check("granted_v_i_held", 32'(req_v[obs_src]), 32'd1);
      if (!m_busy) begin
         w = pick(req_v, m_ptr);
         if (w >= 0) grant_word(w);
      end else if (ready) begin
         void'(m_q.pop_front());
         if (m_q.size() == 0) begin
            m_ptr = (m_src + 1) % ELS;
            w = pick(req_v & ~(ELS'(1) << m_src), m_ptr);
            if (w >= 0) grant_word(w);
            else m_busy = 1'b0;
         end
      end
      @(posedge clk_i);
      #1;
      req_v = req_v & ~e_yumi;
   endtask

   // Asynchronous reset pulse between edges; outputs must clear before any edge.
   task automatic apply_reset(input string tag);
      reset_n_i = 1'b0;
      #1;
      check({tag, "_v_o"},    32'(ch.v_o),    32'd0);
      check({tag, "_yumi_o"}, 32'(ch.yumi_o), 32'd0);
      check({tag, "_data_o"}, 32'(ch.data_o), 32'd0);
      m_busy = 1'b0;
      m_ptr  = 0;
      m_q.delete();
      #1;
      reset_n_i = 1'b1;
   endtask

   int seq3 [9];
   int yumi1_cnt;
   int ready_pct, raise_pct;

   initial begin
      reset_n_i = 1'b0;
      ready     = 1'b0;
      req_v     = '0;
      for (int k = 0; k < ELS; k++) words[k] = '0;
      m_busy = 1'b0;
      m_ptr  = 0;
      seq3   = '{0, 0, 1, 1, 2, 2, 3, 3, 0};

      #12;
      check("rst_v_o",      32'(ch.v_o),      32'd0);
      check("rst_data_o",   32'(ch.data_o),   32'd0);
      check("rst_src_id_o", 32'(ch.src_id_o), 32'd0);
      check("rst_last_o",   32'(ch.last_o),   32'd0);
      check("rst_yumi_o",   32'(ch.yumi_o),   32'd0);
      @(posedge clk_i);
      #1;
      reset_n_i = 1'b1;

      // Single word, no backpressure.
      raise(0, 16'hBEEF);
      ready = 1'b1;
      cycle();
      cycle();
      check("t1_b0_data", 32'(obs_data), 32'h00EF);
      check("t1_b0_last", 32'(obs_last), 32'd0);
      cycle();
      check("t1_b1_data", 32'(obs_data), 32'h00BE);
      check("t1_b1_yumi", 32'(obs_yumi), 32'b0001);
      cycle();
      check("t1_after_v", 32'(obs_v), 32'd0);

      // Backpressure on beat 0.
      raise(0, 16'hBEEF);
      ready = 1'b0;
      cycle();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("t2_hold_data", 32'(obs_data), 32'h00EF);
         check("t2_hold_yumi", 32'(obs_yumi), 32'd0);
      end
      ready = 1'b1;
      cycle();
      cycle();
      check("t2_b1_data", 32'(obs_data), 32'h00BE);
      check("t2_b1_yumi", 32'(obs_yumi), 32'b0001);
      cycle();

      // Fairness from reset with every requester continuously valid.
      apply_reset("t3_rst");
      for (int k = 0; k < ELS; k++) raise(k, {8'hA0 + 8'(k), 8'h50 + 8'(k)});
      cycle();
      for (int i = 0; i < 9; i++) begin
         cycle();
         check("t3_src", 32'(obs_src), 32'(seq3[i]));
         check("t3_v",   32'(obs_v),   32'd1);
         check("t3_yumi", 32'(obs_yumi), (i % 2 == 1) ? 32'(1 << seq3[i]) : 32'd0);
         for (int k = 0; k < ELS; k++)
            if (!req_v[k]) raise(k, WI'($urandom()));
      end
      for (int i = 0; i < 10; i++) cycle();

      // Pointer rotation after requester 2 finishes.
      raise(2, 16'h2222);
      cycle();
      cycle();
      cycle();
      check("t4_yumi2", 32'(obs_yumi), 32'b0100);
      raise(1, 16'h1111);
      raise(3, 16'h3333);
      cycle();
      cycle();
      check("t4_first_src", 32'(obs_src), 32'd3);
      cycle();
      cycle();
      check("t4_second_src", 32'(obs_src), 32'd1);
      cycle();
      cycle();

      // Reset mid-word drops the partial word; it restarts from beat 0.
      raise(1, 16'h1234);
      cycle();
      cycle();
      check("t5_b0_data", 32'(obs_data), 32'h0034);
      apply_reset("t5_rst");
      cycle();
      cycle();
      check("t5_resend_b0", 32'(obs_data), 32'h0034);
      check("t5_resend_src", 32'(obs_src), 32'd1);
      cycle();
      check("t5_resend_b1", 32'(obs_data), 32'h0012);
      cycle();

      // Two words from one requester: exactly one idle cycle between them.
      yumi1_cnt = 0;
      raise(1, 16'hAAAA);
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (obs_yumi[1] === 1'b1) yumi1_cnt++;
      end
      raise(1, 16'h5555);
      cycle();
      check("t6_gap_v", 32'(obs_v), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cycle();
         if (obs_yumi[1] === 1'b1) yumi1_cnt++;
         if (i == 0) check("t6_w2_b0", 32'(obs_data), 32'h0055);
      end
      check("t6_yumi1_count", 32'(yumi1_cnt), 32'd2);

      // Random traffic with varying backpressure and request density.
      for (int blk = 0; blk < 6; blk++) begin
         ready_pct = (blk % 3 == 0) ? 100 : 30 + 20 * blk;
         raise_pct = (blk % 2 == 0) ? 90 : 25;
         if (blk == 3) apply_reset("rnd_rst");
         for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < ELS; k++)
               if (!req_v[k] && ($urandom_range(0, 99) < raise_pct)) raise(k, WI'($urandom()));
            ready = ($urandom_range(0, 99) < ready_pct);
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/bsg_channel_narrow_rr.md
# bsg_channel_narrow_rr

Round-robin scheduler that shares one narrow output channel among `els_p` wide requesters. It grants one requester at a time and sequences that requester's `width_in_p` word out as `width_in_p/width_out_p` narrow beats, low slice first. It dequeues the wide word only after the last beat is accepted. It sits in front of a narrow link or serializer where several wide producers contend for one narrow port.

## Interface
- `els_p`, default 4: number of requesters; must be at least 2.
- `width_in_p`, default 16: requester word width.
- `width_out_p`, default 8: narrow beat width.
  - Must divide `width_in_p` exactly.
  - `beats_lp = width_in_p/width_out_p` must be at least 2.
- `clk_i` input, 1 bit: the single clock.
- `reset_n_i` input, 1 bit: reset, asynchronous and active-low.
- `v_i` input, `els_p` bits: per-requester word valid.
- `data_i` input, `els_p*width_in_p` bits: requester k occupies bits `[k*width_in_p +: width_in_p]`.
- `yumi_o` output, `els_p` bits: one-hot dequeue of requester k's word, high for the cycle its last beat is accepted.
- `v_o` output, 1 bit: narrow beat valid.
- `data_o` output, `width_out_p` bits: narrow beat; all zeros when `v_o` is 0.
- `src_id_o` output, `max(1,$clog2(els_p))` bits: index of the granted requester; 0 when `v_o` is 0.
- `last_o` output, 1 bit: current beat is the final beat of the word.
- `ready_i` input, 1 bit: consumer accepts the beat this cycle. A handshake is `v_o & ready_i`.

## Operation
- State: `IDLE` or `SEND`, plus `grant_r` (requester index), `beat_r` (0..`beats_lp`-1) and `ptr_r` (highest-priority requester).
- Arbitration picks the first requester with `v_i` set, scanning `ptr_r`, `ptr_r+1`, … with wrap at `els_p`.
- `IDLE`:
  - `v_o`=0 and `yumi_o`=0.
  - If any `v_i` is set: `grant_r` ← winner, `beat_r` ← 0, next state `SEND`.
- `SEND`:
  - `v_o`=1; `src_id_o`=`grant_r`.
  - `data_o` = bits `[beat_r*width_out_p +: width_out_p]` of requester `grant_r`'s word.
  - `last_o` = (`beat_r` == `beats_lp`-1).
- Handshake on a non-last beat: `beat_r` increments.
- No handshake: all state holds and `data_o` stays stable.
- Handshake on the last beat:
  - `yumi_o[grant_r]`=1.
  - `ptr_r` ← `grant_r`+1, wrapping to 0 when `grant_r` is `els_p`-1.
  - `beat_r` ← 0.
  - Re-arbitrate the same cycle with requester `grant_r`'s `v_i` masked off, using the new pointer.
  - If a winner exists, `grant_r` ← winner and the state stays `SEND`. Otherwise the state goes to `IDLE`.
- Requester obligations:
  - Once `v_i[k]` is high, `v_i[k]` and its data stay stable until `yumi_o[k]`.
  - Dropping `v_i[k]` while granted is a protocol violation; the resulting behaviour is undefined.
  - The bench flags it as an error.
- A requester never receives two grants without an intervening `IDLE` cycle or a grant to another requester. This prevents a same-cycle reuse of a word that is being dequeued.
- `yumi_o` is combinational from state and `ready_i`. `v_o`, `data_o`, `src_id_o` and `last_o` depend only on registers and `data_i`; they have no combinational path from `ready_i`.

## Timing
- Reset: asserting `reset_n_i` low clears the block immediately, without waiting for a clock edge:
  - State becomes `IDLE`.
  - `grant_r`, `beat_r` and `ptr_r` become 0.
  - `v_o`, `yumi_o`, `data_o`, `src_id_o` and `last_o` become 0.
- Reset mid-word drops the partial word without a `yumi_o`. After reset release, that word is re-sent from beat 0.
- First-beat latency: `v_i` rising in `IDLE` gives `v_o`=1 on the next cycle.
- A word with `ready_i` held high takes `beats_lp` cycles.
- Back-to-back words from different requesters have zero bubble cycles.
- Consecutive words from the same requester, with no other requester valid, have exactly one `IDLE` cycle between them.
- Fairness: with all requesters continuously valid, the grant sequence is 0,1,…,`els_p`-1,0,… from reset.
- Each requester is served within `(els_p-1)*beats_lp` accepted beats after its `v_i` rises, plus any backpressure cycles.

## Test plan
1. Defaults, only `v_i[0]` high with word `0xBEEF`, `ready_i`=1.
   - Cycle 1: `v_o`=1, `data_o`=`0xEF`, `src_id_o`=0, `last_o`=0.
   - Cycle 2: `data_o`=`0xBE`, `last_o`=1, `yumi_o`=`4'b0001`.
   - Cycle 3: `v_o`=0.
2. Same word, `ready_i`=0 for 3 cycles on beat 0.
   - `data_o` holds `0xEF` with `v_o`=1 and `yumi_o`=0 throughout.
   - After `ready_i` rises, beat 1 is `0xBE` and `yumi_o[0]` fires once.
3. All four requesters valid with distinct words, `ready_i`=1.
   - `src_id_o` sequence is 0,0,1,1,2,2,3,3,0 with no `v_o` gaps.
   - `yumi_o` is one-hot on every second cycle.
4. Pointer rotation: after requester 2's word finishes, only `v_i[1]` and `v_i[3]` are high.
   - Requester 3 is granted first, then requester 1.
5. Reset mid-word: pull `reset_n_i` low between clock edges after the beat-0 handshake of requester 1's `0x1234`.
   - `v_o` goes to 0 before the next edge, with no `yumi_o`.
   - After release with `v_i[1]` still high: beats `0x34`, then `0x12`, with `src_id_o`=1.
6. Requester 1 presents two words, `0xAAAA` then `0x5555`, and no other requester is valid.
   - One `v_o`=0 cycle separates `0xAA`,`0xAA` from `0x55`,`0x55`.
   - `yumi_o[1]` fires exactly twice.
